// File: rtl/lc3_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : lc3_control_fsm
// Purpose  : Multi-cycle control unit for an LC-3 style datapath. Sequences
//            fetch / decode / execute, holds the SRAM strobes for MEM_WAIT
//            cycles per access and implements the Run / Continue handshake.
// Ports    : Clk, Reset (sync, active-high), Run, Continue
//            opcode[3:0], BEN, imm5_sel           - status from datapath
//            load_* / ld_reg                      - register load enables
//            pc_sel, ALUK, *_mux_sel              - mux selects
//            GatePC/GateMDR/GateALU/GateMARMUX    - bus drivers (one-hot0)
//            Mem_CE/Mem_OE/Mem_WE                 - SRAM strobes, active-low
//            halted, state_dbg[4:0]               - status / debug
// Options  : LC3_CTRL_ILLEGAL_TRAP_EN - unsupported opcodes halt the core with
//            a sticky trap flag (state_dbg = 5'h1F) cleared only by Reset.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] opcode,
  input  logic       BEN,
  input  logic       imm5_sel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       load_mdr,
  output logic       load_mar,
  output logic       load_cc,
  output logic       ld_reg,
  output logic [1:0] pc_sel,
  output logic [1:0] ALUK,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       SR2_mux_sel,
  output logic       addr1mux_sel,
  output logic [1:0] addr2mux_sel,
  output logic       dr_mux_sel,
  output logic       Mem_CE,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       halted,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    S_HALTED = 5'd0,  S_FETCH1 = 5'd1,  S_FETCH2 = 5'd2,  S_FETCH3 = 5'd3,
    S_DECODE = 5'd4,  S_ALU    = 5'd5,  S_BR     = 5'd6,  S_JMP    = 5'd7,
    S_JSR1   = 5'd8,  S_JSR2   = 5'd9,  S_LDR1   = 5'd10, S_LDR2   = 5'd11,
    S_LDR3   = 5'd12, S_STR1   = 5'd13, S_STR2   = 5'd14, S_STR3   = 5'd15,
    S_STR4   = 5'd16, S_PAUSE1 = 5'd17, S_PAUSE2 = 5'd18
  } state_t;

  typedef struct packed {
    logic       load_ir, load_pc, load_mdr, load_mar, load_cc, ld_reg;
    logic [1:0] pc_sel, aluk;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic       sr2, addr1;
    logic [1:0] addr2;
    logic       dr, mem_ce, mem_oe, mem_we, halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE  = '{mem_ce: 1'b1, mem_oe: 1'b1, mem_we: 1'b1, default: '0};
  // Reset cycle also loads PC with zero through the pc_sel=11 input.
  localparam ctrl_t CTRL_RESET = '{load_pc: 1'b1, pc_sel: 2'b11, mem_ce: 1'b1, mem_oe: 1'b1,
                                   mem_we: 1'b1, halted: 1'b1, default: '0};
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
`ifdef LC3_CTRL_ILLEGAL_TRAP_EN
  logic       trap_q, trap_d;
`endif

  // Next state and the control word of that next state; the word is then
  // registered so every output is glitch-free during its state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = CTRL_IDLE;
`ifdef LC3_CTRL_ILLEGAL_TRAP_EN
    trap_d  = trap_q;
`endif
    case (state_q)
`ifdef LC3_CTRL_ILLEGAL_TRAP_EN
      S_HALTED: if (Run && !trap_q) state_d = S_FETCH1;
`else
      S_HALTED: if (Run) state_d = S_FETCH1;
`endif
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: if (cnt_q == WAIT_LAST) state_d = S_FETCH3; else cnt_d = cnt_q + 4'd1;
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
          4'b0000: state_d = S_BR;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR1;
          4'b0110: state_d = S_LDR1;
          4'b0111: state_d = S_STR1;
          4'b1101: state_d = S_PAUSE1;
`ifdef LC3_CTRL_ILLEGAL_TRAP_EN
          default: begin
            state_d = S_HALTED;
            trap_d  = 1'b1;
          end
`else
          default: state_d = S_FETCH1;
`endif
        endcase
      end
      S_ALU, S_BR, S_JMP, S_JSR2, S_LDR3, S_STR4: state_d = S_FETCH1;
      S_JSR1:   state_d = S_JSR2;
      S_LDR1:   state_d = S_LDR2;
      S_LDR2:   if (cnt_q == WAIT_LAST) state_d = S_LDR3; else cnt_d = cnt_q + 4'd1;
      S_STR1:   state_d = S_STR2;
      S_STR2:   state_d = S_STR3;
      S_STR3:   if (cnt_q == WAIT_LAST) state_d = S_STR4; else cnt_d = cnt_q + 4'd1;
      S_PAUSE1: if (Continue) state_d = S_PAUSE2;
      S_PAUSE2: if (!Continue) state_d = S_FETCH1;
      default:  state_d = S_HALTED;
    endcase

    // Every state change restarts the wait counter, so each memory state
    // starts counting from zero.
    if (state_d != state_q) cnt_d = '0;

    case (state_d)
      S_HALTED: ctrl_d.halted = 1'b1;
      S_FETCH1: begin
        ctrl_d.gate_pc  = 1'b1;
        ctrl_d.load_mar = 1'b1;
        ctrl_d.pc_sel   = 2'b01;
        ctrl_d.load_pc  = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        ctrl_d.mem_ce   = 1'b0;
        ctrl_d.mem_oe   = 1'b0;
        ctrl_d.load_mdr = 1'b1;
      end
      S_FETCH3: begin
        ctrl_d.gate_mdr = 1'b1;
        ctrl_d.load_ir  = 1'b1;
      end
      // Only reachable from DECODE, so opcode/imm5_sel/BEN are the current IR's.
      S_ALU: begin
        case (opcode)
          4'b0101: ctrl_d.aluk = 2'b01;
          4'b1001: ctrl_d.aluk = 2'b10;
          default: ctrl_d.aluk = 2'b00;
        endcase
        ctrl_d.sr2      = (opcode == 4'b1001) ? 1'b0 : imm5_sel;
        ctrl_d.gate_alu = 1'b1;
        ctrl_d.ld_reg   = 1'b1;
        ctrl_d.load_cc  = 1'b1;
      end
      S_BR: if (BEN) begin
        ctrl_d.pc_sel  = 2'b10;
        ctrl_d.addr2   = 2'b10;
        ctrl_d.load_pc = 1'b1;
      end
      S_JMP: begin
        ctrl_d.pc_sel  = 2'b10;
        ctrl_d.addr1   = 1'b1;
        ctrl_d.load_pc = 1'b1;
      end
      S_JSR1: begin
        ctrl_d.gate_pc = 1'b1;
        ctrl_d.dr      = 1'b1;
        ctrl_d.ld_reg  = 1'b1;
      end
      S_JSR2: begin
        ctrl_d.pc_sel  = 2'b10;
        ctrl_d.addr2   = 2'b11;
        ctrl_d.load_pc = 1'b1;
      end
      S_LDR1, S_STR1: begin
        ctrl_d.gate_marmux = 1'b1;
        ctrl_d.addr1       = 1'b1;
        ctrl_d.addr2       = 2'b01;
        ctrl_d.load_mar    = 1'b1;
      end
      S_LDR3: begin
        ctrl_d.gate_mdr = 1'b1;
        ctrl_d.ld_reg   = 1'b1;
        ctrl_d.load_cc  = 1'b1;
      end
      S_STR2: begin
        ctrl_d.aluk     = 2'b11;
        ctrl_d.gate_alu = 1'b1;
        ctrl_d.load_mdr = 1'b1;
      end
      S_STR3: begin
        ctrl_d.gate_mdr = 1'b1;
        ctrl_d.mem_ce   = 1'b0;
        ctrl_d.mem_we   = 1'b0;
      end
      // Data stays on the bus one cycle past the write strobe (hold time).
      S_STR4: ctrl_d.gate_mdr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_HALTED;
      cnt_q   <= '0;
      ctrl_q  <= CTRL_RESET;
`ifdef LC3_CTRL_ILLEGAL_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
`ifdef LC3_CTRL_ILLEGAL_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign load_ir      = ctrl_q.load_ir;
  assign load_pc      = ctrl_q.load_pc;
  assign load_mdr     = ctrl_q.load_mdr;
  assign load_mar     = ctrl_q.load_mar;
  assign load_cc      = ctrl_q.load_cc;
  assign ld_reg       = ctrl_q.ld_reg;
  assign pc_sel       = ctrl_q.pc_sel;
  assign ALUK         = ctrl_q.aluk;
  assign GatePC       = ctrl_q.gate_pc;
  assign GateMDR      = ctrl_q.gate_mdr;
  assign GateALU      = ctrl_q.gate_alu;
  assign GateMARMUX   = ctrl_q.gate_marmux;
  assign SR2_mux_sel  = ctrl_q.sr2;
  assign addr1mux_sel = ctrl_q.addr1;
  assign addr2mux_sel = ctrl_q.addr2;
  assign dr_mux_sel   = ctrl_q.dr;
  assign Mem_CE       = ctrl_q.mem_ce;
  assign Mem_OE       = ctrl_q.mem_oe;
  assign Mem_WE       = ctrl_q.mem_we;
  assign halted       = ctrl_q.halted;
`ifdef LC3_CTRL_ILLEGAL_TRAP_EN
  assign state_dbg    = trap_q ? 5'h1F : state_q;
`else
  assign state_dbg    = state_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc3_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_control_fsm
// Purpose  : Directed scoreboard bench for lc3_control_fsm (MEM_WAIT = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_control_fsm;
  localparam int MW = 3;

  localparam logic [4:0] ST_HALT = 5'd0,  ST_F1 = 5'd1,  ST_F2 = 5'd2,  ST_F3 = 5'd3;
  localparam logic [4:0] ST_DEC = 5'd4,   ST_ALU = 5'd5, ST_BR = 5'd6,  ST_JMP = 5'd7;
  localparam logic [4:0] ST_JSR1 = 5'd8,  ST_JSR2 = 5'd9, ST_LDR1 = 5'd10, ST_LDR2 = 5'd11;
  localparam logic [4:0] ST_LDR3 = 5'd12, ST_STR1 = 5'd13, ST_STR2 = 5'd14, ST_STR3 = 5'd15;
  localparam logic [4:0] ST_STR4 = 5'd16, ST_P1 = 5'd17, ST_P2 = 5'd18, ST_TRAP = 5'h1F;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, BEN, imm5_sel;
  logic [3:0] opcode;
  logic       load_ir, load_pc, load_mdr, load_mar, load_cc, ld_reg;
  logic [1:0] pc_sel, ALUK, addr2mux_sel;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       SR2_mux_sel, addr1mux_sel, dr_mux_sel;
  logic       Mem_CE, Mem_OE, Mem_WE, halted;
  logic [4:0] state_dbg;

  lc3_control_fsm #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .opcode(opcode), .BEN(BEN), .imm5_sel(imm5_sel),
    .load_ir(load_ir), .load_pc(load_pc), .load_mdr(load_mdr), .load_mar(load_mar),
    .load_cc(load_cc), .ld_reg(ld_reg), .pc_sel(pc_sel), .ALUK(ALUK),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .SR2_mux_sel(SR2_mux_sel), .addr1mux_sel(addr1mux_sel), .addr2mux_sel(addr2mux_sel),
    .dr_mux_sel(dr_mux_sel), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .halted(halted), .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0] st;
    logic       ld_ir, ld_pc, ld_mdr, ld_mar, ld_cc, ld_reg;
    logic [1:0] pcs, aluk;
    logic       gpc, gmdr, galu, gmm, sr2, a1;
    logic [1:0] a2;
    logic       dr, ce, oe, we, hlt;
  } obs_t;

  typedef struct {
    int    cyc;
    obs_t  e;
    string nm;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: the control word is presented every cycle, so each negedge
  // retires whatever expectation was scheduled for this cycle.
  always @(negedge Clk) begin
    obs_t a;
    exp_t x;
    a = '{st: state_dbg, ld_ir: load_ir, ld_pc: load_pc, ld_mdr: load_mdr,
          ld_mar: load_mar, ld_cc: load_cc, ld_reg: ld_reg, pcs: pc_sel, aluk: ALUK,
          gpc: GatePC, gmdr: GateMDR, galu: GateALU, gmm: GateMARMUX,
          sr2: SR2_mux_sel, a1: addr1mux_sel, a2: addr2mux_sel, dr: dr_mux_sel,
          ce: Mem_CE, oe: Mem_OE, we: Mem_WE, hlt: halted};
    total++;
    if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1) begin
      bad++;
      $display("FAIL gates_onehot cyc=%0d got=%b required at most one high", cyc,
               {GatePC, GateMDR, GateALU, GateMARMUX});
    end
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      x = sbq.pop_front();
      total++;
      if (x.cyc != cyc || a !== x.e) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h required=%h", x.nm, cyc, a, x.e);
      end
    end
  end

  function automatic obs_t base(input logic [4:0] st);
    obs_t o = '0;
    o.st  = st;
    o.ce  = 1'b1;
    o.oe  = 1'b1;
    o.we  = 1'b1;
    o.hlt = (st == ST_HALT) || (st == ST_TRAP);
    return o;
  endfunction

  function automatic obs_t rst_o();
    obs_t o = base(ST_HALT);
    o.ld_pc = 1'b1;
    o.pcs   = 2'b11;
    return o;
  endfunction

  function automatic obs_t f1();
    obs_t o = base(ST_F1);
    o.gpc = 1'b1; o.ld_mar = 1'b1; o.pcs = 2'b01; o.ld_pc = 1'b1;
    return o;
  endfunction

  function automatic obs_t memrd(input logic [4:0] st);
    obs_t o = base(st);
    o.ce = 1'b0; o.oe = 1'b0; o.ld_mdr = 1'b1;
    return o;
  endfunction

  function automatic obs_t eff_addr(input logic [4:0] st);
    obs_t o = base(st);
    o.gmm = 1'b1; o.a1 = 1'b1; o.a2 = 2'b01; o.ld_mar = 1'b1;
    return o;
  endfunction

  // Schedule the outputs expected after the next rising edge, then take it.
  task automatic step(input obs_t e, input string nm);
    exp_t x;
    x.cyc = cyc + 1;
    x.e   = e;
    x.nm  = nm;
    sbq.push_back(x);
    @(posedge Clk);
    #1;
  endtask

  // Precondition: DUT is in FETCH1. Leaves it in DECODE.
  task automatic fetch_dec(input logic [3:0] op, input logic imm, input logic ben);
    obs_t e;
    for (int i = 0; i < MW; i++) step(memrd(ST_F2), "fetch2");
    opcode = op; imm5_sel = imm; BEN = ben;
    e = base(ST_F3); e.gmdr = 1'b1; e.ld_ir = 1'b1;
    step(e, "fetch3");
    step(base(ST_DEC), "decode");
  endtask

  task automatic alu(input logic [3:0] op, input logic imm, input logic [1:0] k, input logic s2);
    obs_t e;
    fetch_dec(op, imm, 1'b0);
    e = base(ST_ALU); e.aluk = k; e.sr2 = s2; e.galu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
    step(e, "alu");
    step(f1(), "alu_ret");
  endtask

  initial begin
    obs_t e;
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; opcode = 4'h0; BEN = 1'b0; imm5_sel = 1'b0;
    @(posedge Clk);
    #1;
    step(rst_o(), "reset");
    step(rst_o(), "reset_hold");
    Reset = 1'b0;
    step(base(ST_HALT), "halted_idle");
    step(base(ST_HALT), "halted_idle2");
    Run = 1'b1;
    step(f1(), "run_fetch1");
    Run = 1'b0;                           // no effect outside HALTED

    alu(4'b0001, 1'b1, 2'b00, 1'b1);      // ADD R1,R1,#1 (0x1261)
    alu(4'b0101, 1'b0, 2'b01, 1'b0);      // AND register
    alu(4'b0101, 1'b1, 2'b01, 1'b1);      // AND immediate
    alu(4'b1001, 1'b1, 2'b10, 1'b0);      // NOT forces SR2 select low

    fetch_dec(4'b0000, 1'b0, 1'b0);
    step(base(ST_BR), "br_not_taken");
    step(f1(), "br_nt_ret");
    fetch_dec(4'b0000, 1'b0, 1'b1);
    e = base(ST_BR); e.pcs = 2'b10; e.a2 = 2'b10; e.ld_pc = 1'b1;
    step(e, "br_taken");
    step(f1(), "br_t_ret");

    fetch_dec(4'b1100, 1'b0, 1'b0);
    e = base(ST_JMP); e.pcs = 2'b10; e.a1 = 1'b1; e.ld_pc = 1'b1;
    step(e, "jmp");
    step(f1(), "jmp_ret");

    fetch_dec(4'b0100, 1'b0, 1'b0);
    e = base(ST_JSR1); e.gpc = 1'b1; e.dr = 1'b1; e.ld_reg = 1'b1;
    step(e, "jsr1");
    e = base(ST_JSR2); e.pcs = 2'b10; e.a2 = 2'b11; e.ld_pc = 1'b1;
    step(e, "jsr2");
    step(f1(), "jsr_ret");

    fetch_dec(4'b0110, 1'b0, 1'b0);
    step(eff_addr(ST_LDR1), "ldr1");
    for (int i = 0; i < MW; i++) step(memrd(ST_LDR2), "ldr2");
    e = base(ST_LDR3); e.gmdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
    step(e, "ldr3");
    step(f1(), "ldr_ret");

    fetch_dec(4'b0111, 1'b0, 1'b0);
    step(eff_addr(ST_STR1), "str1");
    e = base(ST_STR2); e.aluk = 2'b11; e.galu = 1'b1; e.ld_mdr = 1'b1;
    step(e, "str2");
    e = base(ST_STR3); e.gmdr = 1'b1; e.ce = 1'b0; e.we = 1'b0;
    for (int i = 0; i < MW; i++) step(e, "str3_write");
    e = base(ST_STR4); e.gmdr = 1'b1;
    step(e, "str_hold");
    step(f1(), "str_ret");

    fetch_dec(4'b1101, 1'b0, 1'b0);
    step(base(ST_P1), "pause1");
    step(base(ST_P1), "pause1_wait");
    Continue = 1'b1;
    for (int i = 0; i < 10; i++) step(base(ST_P2), "pause2_held");
    Continue = 1'b0;
    step(f1(), "pause_release");

    Run = 1'b1;
    fetch_dec(4'b1111, 1'b0, 1'b0);
`ifdef LC3_CTRL_ILLEGAL_TRAP_EN
    step(base(ST_TRAP), "illegal_trap");
    for (int i = 0; i < 3; i++) step(base(ST_TRAP), "trap_ignores_run");
    Reset = 1'b1;
    step(rst_o(), "trap_reset");
    Reset = 1'b0;
    step(f1(), "trap_cleared_run");
    Run = 1'b0;
`else
    step(f1(), "illegal_nop");
    Run = 1'b0;
`endif

    fetch_dec(4'b0110, 1'b0, 1'b0);
    step(eff_addr(ST_LDR1), "ldr1_b");
    step(memrd(ST_LDR2), "ldr2_b");
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) step(rst_o(), "reset_mid_ldr2");
    Reset = 1'b0;
    step(base(ST_HALT), "post_reset_halted");

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge Clk);
    if (sbq.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lc3_control_fsm.md
Name: lc3_control_fsm

Overview:
- Multi-cycle control unit that sequences the LC-3 style datapath: fetch, decode, execute, plus run/pause handshake with the board switches.
- Drives every load, gate and mux-select input of the datapath and the active-low SRAM strobes.
- Consumes the opcode, BEN and imm5 select that the datapath returns.
- Sits beside the datapath inside the processor top level; it is the only writer of datapath control inputs.

Parameters:
- MEM_WAIT, 2, cycles each memory read/write strobe is held; legal range 1..15.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  level; starts execution from HALTED.
- Continue  in  1  level; releases PAUSE.
- opcode  in  4  IR[15:12] from datapath.
- BEN  in  1  branch-enable from nzp compare.
- imm5_sel  in  1  IR[5], selects register vs immediate operand.
- load_ir, load_pc, load_mdr, load_mar, load_cc, ld_reg  out  1 each  register loads.
- pc_sel  out  2  00 bus, 01 PC+1, 10 address adder, 11 zero.
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers.
  - Exactly one, or none, is high in any cycle.
- SR2_mux_sel  out  1  0 SR2, 1 sext(imm5).
- addr1mux_sel  out  1  0 PC, 1 SR1.
- addr2mux_sel  out  2  00 zero, 01 off6, 10 off9, 11 off11.
- dr_mux_sel  out  1  0 IR[11:9], 1 R7.
- Mem_CE, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low.
- halted  out  1  high in HALTED.
- state_dbg  out  5  current state encoding, for hex display.

Behaviour:
- Reset (synchronous, wins over all inputs, any state):
  - State goes to HALTED; wait counter cleared; PC loaded with zero (load_pc=1, pc_sel=11) in the reset cycle.
  - Outputs after reset: all loads 0, all gates 0, all mux selects 0, ALUK 00, Mem_* = 1, halted 1.
- Default outputs: every state drives only the signals listed for it; all others take their reset values.
- HALTED: Run=1 -> FETCH1; otherwise stay.
- FETCH1: GatePC, load_mar, pc_sel=01, load_pc -> FETCH2.
- FETCH2 (memory read):
  - Mem_CE=0, Mem_OE=0, load_mdr=1 on every cycle.
  - Hold MEM_WAIT cycles using a 4-bit counter, then -> FETCH3.
  - The last cycle's MDR capture is the valid one.
- FETCH3: GateMDR, load_ir -> DECODE.
- DECODE: branch on opcode.
  - 0001 ADD, 0101 AND, 1001 NOT -> ALU.
  - 0000 -> BR.
  - 1100 -> JMP.
  - 0100 -> JSR1.
  - 0110 -> LDR1.
  - 0111 -> STR1.
  - 1101 -> PAUSE1.
  - Other opcodes: see Optional Feature.
- ALU state:
  - ALUK = ADD, AND or NOT per opcode; SR2_mux_sel=imm5_sel (forced 0 for NOT).
  - GateALU, ld_reg, load_cc -> FETCH1.
- BR: if BEN=1: pc_sel=10, addr1mux_sel=0, addr2mux_sel=10, load_pc. -> FETCH1 either way.
- JMP: pc_sel=10, addr1mux_sel=1, addr2mux_sel=00, load_pc -> FETCH1.
- JSR1: GatePC, dr_mux_sel=1, ld_reg -> JSR2.
- JSR2: pc_sel=10, addr1mux_sel=0, addr2mux_sel=11, load_pc -> FETCH1.
- LDR1: GateMARMUX, addr1mux_sel=1, addr2mux_sel=01, load_mar -> LDR2.
- LDR2: read exactly as FETCH2 (MEM_WAIT cycles) -> LDR3.
- LDR3: GateMDR, ld_reg, load_cc -> FETCH1.
- STR1: as LDR1 -> STR2.
- STR2: ALUK=PASSA, GateALU, load_mdr -> STR3.
- STR3 (memory write):
  - GateMDR, Mem_CE=0, Mem_WE=0 for MEM_WAIT cycles.
  - Then one cycle with GateMDR held and Mem_WE=1 (data hold) -> FETCH1.
- PAUSE1: wait for Continue=1 -> PAUSE2.
- PAUSE2: wait for Continue=0 -> FETCH1. Exactly one instruction advance per press.
- Run is sampled only in HALTED; Run deasserting mid-program has no effect.
- Counter rules:
  - Cleared on entry to every memory state; compared to MEM_WAIT-1.
  - Never wraps: the state exits at terminal count.

Optional Feature:
- Macro: LC3_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE goes to HALTED.
  - A sticky internal flag is set; state_dbg reads 5'h1F while the flag is set.
  - Only Reset clears the flag; Run is ignored while it is set.
- Undefined: an unsupported opcode behaves as NOP (DECODE -> FETCH1); no flag logic is synthesized.

Test Plan:
- Reset held 3 cycles mid-LDR2 -> next cycle state HALTED, Mem_OE=1, halted=1; PC load with pc_sel=11 observed.
- Run=1, MEM_WAIT=2, memory[0]=16'h1261 (ADD R1,R1,#1) -> FETCH1..ALU in 6 cycles; ALU cycle has SR2_mux_sel=1, GateALU=1, ld_reg=1, load_cc=1.
- opcode 0000 with BEN=0 -> no load_pc in BR; with BEN=1 -> load_pc=1, pc_sel=10, addr2mux_sel=10.
- STR with MEM_WAIT=3 -> Mem_WE=0 exactly 3 cycles; GateMDR high for 4 cycles; never two gates high together.
- opcode 1101 with Continue held high 10 cycles -> exactly one return to FETCH1 after release.
- opcode 1111 -> with macro: HALTED, state_dbg=5'h1F, Run ignored until Reset; without macro: FETCH1 next.
